// File: rtl/lane_scroll_ctrl.sv
// Lane scroll controller: per-lane scroll offsets updated once per frame.
// Optional level speedup is enabled by defining LANE_LEVEL_SPEEDUP_EN.
module lane_scroll_ctrl #(
  parameter int PLAY_W    = 448,
  parameter int NUM_LANES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       run,
  input  logic [1:0] level,
  input  logic [9:0] rowPos,
  output logic [8:0] lane_offset,
  output logic       lane_hit,
  output logic       lane_dir,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [8:0] PW = 9'(PLAY_W);
  localparam logic [IW-1:0] LAST = IW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  logic [8:0] off_q [NUM_LANES];
  logic [8:0] off_d [NUM_LANES];
  logic [1:0] cnt_q [NUM_LANES];
  logic [1:0] cnt_d [NUM_LANES];

  logic [8:0] lane_offset_q, lane_offset_d;
  logic       lane_hit_q, lane_hit_d;
  logic       lane_dir_q, lane_dir_d;

  logic [8:0] step;

`ifdef LANE_LEVEL_SPEEDUP_EN
  assign step = 9'd1 + {7'd0, level};
`else
  logic unused_level;
  assign step = 9'd1;
  assign unused_level = ^level;
`endif

  // Frames-per-move table, stored as period minus one.
  function automatic logic [1:0] per_m1(input logic [3:0] l);
    logic [1:0] p;
    case (l)
      4'd0:    p = 2'd2;
      4'd1:    p = 2'd1;
      4'd2:    p = 2'd3;
      4'd3:    p = 2'd0;
      4'd4:    p = 2'd2;
      4'd5:    p = 2'd1;
      4'd6:    p = 2'd1;
      4'd7:    p = 2'd2;
      4'd8:    p = 2'd0;
      4'd9:    p = 2'd3;
      4'd10:   p = 2'd1;
      4'd11:   p = 2'd2;
      default: p = 2'd0;
    endcase
    return p;
  endfunction

  // Wrapped move; left wrap adds (PW - step) so nothing exceeds 9 bits.
  function automatic logic [8:0] move(
    input logic [8:0] off,
    input logic [8:0] stp,
    input logic       right
  );
    logic [8:0] sum;
    logic [8:0] r;
    sum = off + stp;
    if (right) r = (sum >= PW) ? sum - PW : sum;
    else       r = (off < stp) ? off + (PW - stp) : off - stp;
    return r;
  endfunction

  // Next-state and registered-output logic for the pass sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (frame_start & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_start && run) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        if (idx_q == LAST) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == UPDATE);
    done_d = (state_d == DONE);
  end

  // Per-lane counter and offset update for the lane being processed.
  always_comb begin
    off_d = off_q;
    cnt_d = cnt_q;
    if (state_q == UPDATE) begin
      if (cnt_q[idx_q] == per_m1(4'(idx_q))) begin
        cnt_d[idx_q] = 2'd0;
        off_d[idx_q] = move(off_q[idx_q], step, ~idx_q[0]);
      end else begin
        cnt_d[idx_q] = cnt_q[idx_q] + 2'd1;
      end
    end
  end

  // Row-to-lane lookup against the current offset registers.
  always_comb begin
    logic [4:0] k;
    logic [4:0] ln;
    logic       in_band;
    k       = rowPos[9:5];
    ln      = 5'd0;
    in_band = 1'b0;
    if (k >= 5'd1 && k <= 5'd6) begin
      ln      = k - 5'd1;
      in_band = 1'b1;
    end else if (k >= 5'd8 && k <= 5'd13) begin
      ln      = k - 5'd2;
      in_band = 1'b1;
    end
    lane_hit_d    = 1'b0;
    lane_dir_d    = 1'b0;
    lane_offset_d = 9'd0;
    if (in_band && (int'(ln) < NUM_LANES)) begin
      lane_hit_d    = 1'b1;
      lane_dir_d    = ~ln[0];
      lane_offset_d = off_q[ln[IW-1:0]];
    end
  end

  // Sequencer state and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Lane offset and frame counter storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        off_q[i] <= 9'd0;
        cnt_q[i] <= 2'd0;
      end
    end else begin
      off_q <= off_d;
      cnt_q <= cnt_d;
    end
  end

  // Registered lookup outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_offset_q <= 9'd0;
      lane_hit_q    <= 1'b0;
      lane_dir_q    <= 1'b0;
    end else begin
      lane_offset_q <= lane_offset_d;
      lane_hit_q    <= lane_hit_d;
      lane_dir_q    <= lane_dir_d;
    end
  end

  assign lane_offset = lane_offset_q;
  assign lane_hit    = lane_hit_q;
  assign lane_dir    = lane_dir_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lane_scroll_ctrl.sv
// Testbench for lane_scroll_ctrl: lookup table vectors plus
// multi-cycle sequences for passes, overrun, run=0 and mid-pass reset.
module tb_lane_scroll_ctrl;

`ifdef LANE_LEVEL_SPEEDUP_EN
  localparam int S = 4;
`else
  localparam int S = 1;
`endif
  localparam int PW = 448;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       run;
  logic [1:0] level;
  logic [9:0] rowPos;
  logic [8:0] lane_offset;
  logic       lane_hit;
  logic       lane_dir;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;

  lane_scroll_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .run         (run),
    .level       (level),
    .rowPos      (rowPos),
    .lane_offset (lane_offset),
    .lane_hit    (lane_hit),
    .lane_dir    (lane_dir),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] row;
    logic       hit;
    logic       dir;
    logic [8:0] off;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_lane(input string nm, input logic [9:0] r,
                          input logic [8:0] eoff, input logic edir);
    @(negedge clk);
    rowPos = r;
    @(posedge clk);
    #1;
    check({nm, "_hit"}, 32'(lane_hit), 32'd1);
    check({nm, "_dir"}, 32'(lane_dir), 32'(edir));
    check({nm, "_off"}, 32'(lane_offset), 32'(eoff));
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pass_check(input string nm);
    pulse_frame();
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("%s_busy_c%0d", nm, c), 32'(busy), 32'(c <= 12));
      check($sformatf("%s_done_c%0d", nm, c), 32'(done), 32'(c == 13));
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{10'd0,    1'b0, 1'b0, 9'd0};
    vecs[1]  = '{10'd40,   1'b1, 1'b1, 9'd0};
    vecs[2]  = '{10'd64,   1'b1, 1'b0, 9'd0};
    vecs[3]  = '{10'd191,  1'b1, 1'b1, 9'd0};
    vecs[4]  = '{10'd192,  1'b1, 1'b0, 9'd0};
    vecs[5]  = '{10'd224,  1'b0, 1'b0, 9'd0};
    vecs[6]  = '{10'd256,  1'b1, 1'b1, 9'd0};
    vecs[7]  = '{10'd320,  1'b1, 1'b1, 9'd0};
    vecs[8]  = '{10'd447,  1'b1, 1'b0, 9'd0};
    vecs[9]  = '{10'd448,  1'b0, 1'b0, 9'd0};
    vecs[10] = '{10'd1023, 1'b0, 1'b0, 9'd0};

    reset       = 1'b1;
    frame_start = 1'b0;
    run         = 1'b0;
    level       = 2'd3;
    rowPos      = 10'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    check("rst_hit", 32'(lane_hit), 32'd0);
    check("rst_off", 32'(lane_offset), 32'd0);
    check("rst_dir", 32'(lane_dir), 32'd0);

    reset  = 1'b0;
    rowPos = 10'd40;
    repeat (2) @(posedge clk);
    #1;
    check("r40_hit", 32'(lane_hit), 32'd1);
    check("r40_off", 32'(lane_offset), 32'd0);
    check("r40_dir", 32'(lane_dir), 32'd1);
    check("r40_busy", 32'(busy), 32'd0);
    check("r40_done", 32'(done), 32'd0);
    check("r40_ovr", 32'(overrun), 32'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rowPos = vecs[i].row;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_hit", i), 32'(lane_hit), 32'(vecs[i].hit));
      check($sformatf("vec%0d_dir", i), 32'(lane_dir), 32'(vecs[i].dir));
      check($sformatf("vec%0d_off", i), 32'(lane_offset), 32'(vecs[i].off));
    end

    run = 1'b1;
    pass_check("f1");
    chk_lane("f1_l3", 10'd128, 9'(PW - S), 1'b0);
    chk_lane("f1_l0", 10'd40, 9'd0, 1'b1);
    chk_lane("f1_l8", 10'd320, 9'(S), 1'b1);

    repeat (2) begin
      pulse_frame();
      repeat (20) @(negedge clk);
    end
    chk_lane("f3_l0", 10'd40, 9'(S), 1'b1);
    chk_lane("f3_l1", 10'd64, 9'(PW - S), 1'b0);
    chk_lane("f3_l2", 10'd96, 9'd0, 1'b1);
    chk_lane("f3_l3", 10'd128, 9'(PW - 3 * S), 1'b0);
    check("f3_ovr", 32'(overrun), 32'd0);

    cnt = 0;
    pulse_frame();
    repeat (3) @(negedge clk);
    pulse_frame();
    for (int c = 0; c < 20; c++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    check("ovr_done_cnt", 32'(cnt), 32'd1);
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (10) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 32'd1);
    chk_lane("f4_l2", 10'd96, 9'(S), 1'b1);
    chk_lane("f4_l3", 10'd128, 9'(PW - 4 * S), 1'b0);
    chk_lane("f4_l0", 10'd40, 9'(S), 1'b1);

    run = 1'b0;
    cnt = 0;
    pulse_frame();
    for (int c = 0; c < 16; c++) begin
      if (busy || done) cnt++;
      @(negedge clk);
    end
    check("run0_busy_cnt", 32'(cnt), 32'd0);
    chk_lane("run0_l3", 10'd128, 9'(PW - 4 * S), 1'b0);
    check("run0_ovr", 32'(overrun), 32'd1);

    run = 1'b1;
    pulse_frame();
    repeat (5) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ovr", 32'(overrun), 32'd0);
    check("mid_rst_hit", 32'(lane_hit), 32'd0);
    check("mid_rst_off", 32'(lane_offset), 32'd0);
    check("mid_rst_dir", 32'(lane_dir), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    check("mid_no_done", 32'(cnt), 32'd0);
    chk_lane("mid_l3", 10'd128, 9'd0, 1'b0);
    pass_check("post");
    chk_lane("post_l3", 10'd128, 9'(PW - S), 1'b0);
    chk_lane("post_l8", 10'd320, 9'(S), 1'b1);
    check("post_ovr", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
